// File: rtl/alu_bus_sequencer.sv
// Bus-side sequencer for the 8-bit Acc/MQ/DR shift-add datapath: loads operands, runs INS until RDY, reads back.
// Optional EXEC timeout abort is compiled in with `define ALU_SEQ_TIMEOUT_EN.
module alu_bus_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_acc,
  output logic [7:0] resp_mq,
  output logic       resp_err,
  output logic       busy,
  output logic [2:0] INS,
  output logic       LDAcc,
  output logic       LDMQ,
  output logic       LDDR,
  output logic       STAcc,
  output logic       STMQ,
  output logic       STDR,
  output logic       TESTMODE,
  output logic [7:0] inBUS,
  input  logic [7:0] outBUS,
  input  logic       RDY
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_DR, S_LD_MQ, S_CLR_ACC, S_EXEC, S_RD_ACC, S_RD_MQ, S_DONE
  } state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("alu_bus_sequencer: TIMEOUT must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d, mq_q, mq_d;
  logic       err_q, err_d;

  logic       req_ready_q, req_ready_d;
  logic       busy_q, busy_d;
  logic       resp_valid_q, resp_valid_d;
  logic [2:0] ins_q, ins_d;
  logic       ldacc_q, ldacc_d, ldmq_q, ldmq_d, lddr_q, lddr_d;
  logic       stacc_q, stacc_d, stmq_q, stmq_d;
  logic [7:0] inbus_q, inbus_d;

  logic       rdy_seen;
  logic       timeout_hit;

  // RDY is only trusted once the datapath has had one full EXEC cycle to react.
  assign rdy_seen = RDY && (cnt_q != 8'd0);

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
  assign timeout_hit = (({1'b0, cnt_q} + 9'd1) == TIMEOUT_LIM);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          err_d   = 1'b0;
          state_d = S_LD_DR;
        end
      end
      S_LD_DR:   state_d = S_LD_MQ;
      S_LD_MQ:   state_d = S_CLR_ACC;
      S_CLR_ACC: begin
        cnt_d   = 8'd0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (rdy_seen) begin
          state_d = S_RD_ACC;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RD_ACC;
        end
      end
      S_RD_ACC: begin
        acc_d   = outBUS;
        state_d = S_RD_MQ;
      end
      S_RD_MQ: begin
        mq_d    = outBUS;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    lddr_d       = (state_d == S_LD_DR);
    ldmq_d       = (state_d == S_LD_MQ);
    ldacc_d      = (state_d == S_CLR_ACC);
    stacc_d      = (state_d == S_RD_ACC);
    stmq_d       = (state_d == S_RD_MQ);
    ins_d        = ((state_d == S_EXEC) || (state_d == S_RD_ACC)) ? op_d : 3'd0;
    inbus_d      = 8'h00;
    if (state_d == S_LD_DR) inbus_d = a_d;
    if (state_d == S_LD_MQ) inbus_d = b_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      cnt_q        <= 8'h00;
      acc_q        <= 8'h00;
      mq_q         <= 8'h00;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      ins_q        <= 3'd0;
      ldacc_q      <= 1'b0;
      ldmq_q       <= 1'b0;
      lddr_q       <= 1'b0;
      stacc_q      <= 1'b0;
      stmq_q       <= 1'b0;
      inbus_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mq_q         <= mq_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      ins_q        <= ins_d;
      ldacc_q      <= ldacc_d;
      ldmq_q       <= ldmq_d;
      lddr_q       <= lddr_d;
      stacc_q      <= stacc_d;
      stmq_q       <= stmq_d;
      inbus_q      <= inbus_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_acc   = acc_q;
  assign resp_mq    = mq_q;
`ifdef ALU_SEQ_TIMEOUT_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif
  assign INS        = ins_q;
  assign LDAcc      = ldacc_q;
  assign LDMQ       = ldmq_q;
  assign LDDR       = lddr_q;
  assign STAcc      = stacc_q;
  assign STMQ       = stmq_q;
  assign STDR       = 1'b0;
  assign TESTMODE   = 1'b0;
  assign inBUS      = inbus_q;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Bench for alu_bus_sequencer: a multiplying datapath stub on the bus side, table plus random host requests.
module tb_alu_bus_sequencer;

  localparam int T = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_a = 8'h00, req_b = 8'h00;
  logic       resp_valid, resp_ready = 1'b0;
  logic [7:0] resp_acc, resp_mq;
  logic       resp_err, busy;
  logic [2:0] INS;
  logic       LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, TESTMODE;
  logic [7:0] inBUS;
  logic [7:0] outBUS = 8'h00;
  logic       RDY = 1'b0;

  alu_bus_sequencer #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_acc(resp_acc), .resp_mq(resp_mq), .resp_err(resp_err), .busy(busy),
    .INS(INS), .LDAcc(LDAcc), .LDMQ(LDMQ), .LDDR(LDDR),
    .STAcc(STAcc), .STMQ(STMQ), .STDR(STDR), .TESTMODE(TESTMODE),
    .inBUS(inBUS), .outBUS(outBUS), .RDY(RDY)
  );

  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;

  // Datapath stub state: it latches operands off inBUS and multiplies them, as the real shift-add unit would.
  logic [7:0] dp_dr = 8'h00, dp_mq = 8'h00;
  int         exec_cnt = 0, rdy_after = 2, ins_bad = 0, excl_bad = 0;
  logic [2:0] cur_op = 3'd0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    int         n;
    int         lat;
    logic [7:0] acc, mq;
    logic       err;
    int         exec;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    logic [5:0]  st;
    logic        in_exec;
    logic [15:0] prod;
    @(negedge clock);
    st = {LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR};
    if ($countones(st) > 1 || STDR || TESTMODE) excl_bad++;
    in_exec = busy && (st == 6'd0) && !resp_valid;
    if (LDDR) dp_dr = inBUS;
    if (LDMQ) dp_mq = inBUS;
    if (LDAcc) exec_cnt = 0;
    if (in_exec) begin
      exec_cnt++;
      if (INS !== cur_op) ins_bad++;
    end
    RDY  = in_exec && (exec_cnt >= rdy_after);
    prod = dp_dr * dp_mq;
    if (STAcc) outBUS = prod[15:8];
    else if (STMQ) outBUS = prod[7:0];
    else outBUS = 8'($urandom);
  endtask

  // Host-level expectation: result is a*b, EXEC lasts max(n,2) cycles, capped by the abort limit when enabled.
  function automatic int ref_exec(input int n);
    int e;
    e = (n < 2) ? 2 : n;
`ifdef ALU_SEQ_TIMEOUT_EN
    if (e > T) e = T;
`endif
    return e;
  endfunction

  function automatic logic ref_err(input int n);
`ifdef ALU_SEQ_TIMEOUT_EN
    return n > T;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int n,
                        input int exp_lat, input logic [7:0] exp_acc, input logic [7:0] exp_mq,
                        input logic exp_err, input int exp_exec);
    int wc, lat;
    cur_op = op; rdy_after = n; ins_bad = 0;
    wc = 0;
    while (!req_ready && wc < 50) begin tick(); wc++; end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
    check("accept_busy", {30'd0, busy, req_ready}, 32'd2);
    check("ld_dr", {23'd0, LDDR, inBUS}, {23'd0, 1'b1, a});
    tick();
    check("ld_mq", {23'd0, LDMQ, inBUS}, {23'd0, 1'b1, b});
    tick();
    check("clr_acc", {23'd0, LDAcc, inBUS}, {23'd0, 1'b1, 8'h00});
    lat = 2;
    while (!resp_valid && lat < 400) begin tick(); lat++; end
    check("latency", lat, exp_lat);
    check("resp_acc", {24'd0, resp_acc}, {24'd0, exp_acc});
    check("resp_mq", {24'd0, resp_mq}, {24'd0, exp_mq});
    check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    check("exec_cycles", exec_cnt, exp_exec);
    check("ins_held", ins_bad, 0);
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("release", {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] rop;
    logic [7:0] ra, rb;
    int rn;
    logic [15:0] p;

    vt[0] = '{3'b101, 8'h05, 8'h03, 2, 7, 8'h00, 8'h0F, 1'b0, 2};
`ifdef ALU_SEQ_TIMEOUT_EN
    vt[1] = '{3'b101, 8'h05, 8'h03, 12, 15, 8'h00, 8'h0F, 1'b1, 10};
`else
    vt[1] = '{3'b101, 8'h05, 8'h03, 12, 17, 8'h00, 8'h0F, 1'b0, 12};
`endif
    vt[2] = '{3'b001, 8'hFF, 8'hFF, 1, 7, 8'hFE, 8'h01, 1'b0, 2};
    vt[3] = '{3'b000, 8'h10, 8'h10, 3, 8, 8'h01, 8'h00, 1'b0, 3};
    vt[4] = '{3'b111, 8'h00, 8'h80, 5, 10, 8'h00, 8'h00, 1'b0, 5};
    vt[5] = '{3'b011, 8'hC8, 8'h02, 10, 15, 8'h01, 8'h90, 1'b0, 10};

    // Reset state while reset is held.
    #3;
    check("reset_outputs",
          {resp_valid, resp_err, busy, INS, LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, TESTMODE, inBUS},
          32'd0);
    check("reset_resp_data", {16'd0, resp_acc, resp_mq}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("ready_after_reset", {30'd0, req_ready, resp_valid}, 32'd2);

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].n, vt[i].lat, vt[i].acc, vt[i].mq, vt[i].err, vt[i].exec);
      release_resp();
    end

    // Backpressure with a second request waiting the whole time.
    run_op(3'b101, 8'h05, 8'h03, 2, 7, 8'h00, 8'h0F, 1'b0, 2);
    req_valid = 1'b1; req_op = 3'b010; req_a = 8'h0C; req_b = 8'h0B;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold", {30'd0, resp_valid, req_ready}, 32'd2);
      check("bp_stable", {15'd0, resp_err, resp_acc, resp_mq}, 32'h000F);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_ready_next", {30'd0, req_ready, resp_valid}, 32'd2);
    run_op(3'b010, 8'h0C, 8'h0B, 4, 9, 8'h00, 8'h84, 1'b0, 4);
    release_resp();

    // Random requests against the host-level model.
    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rn  = $urandom_range(1, 9);
      p   = ra * rb;
      run_op(rop, ra, rb, rn, 5 + ref_exec(rn), p[15:8], p[7:0], ref_err(rn), ref_exec(rn));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      release_resp();
    end

    // RDY never arrives.
`ifdef ALU_SEQ_TIMEOUT_EN
    run_op(3'b110, 8'h07, 8'h09, 100000, 15, 8'h00, 8'h3F, 1'b1, T);
    release_resp();
    run_op(3'b110, 8'h02, 8'h03, 2, 7, 8'h00, 8'h06, 1'b0, 2);
    release_resp();
`else
    cur_op = 3'b110; rdy_after = 100000;
    req_valid = 1'b1; req_op = 3'b110; req_a = 8'h07; req_b = 8'h09;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    check("hang_busy", {30'd0, busy, resp_valid}, 32'd2);
    check("hang_exec", {31'd0, exec_cnt >= 290}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("hang_recover", {30'd0, req_ready, resp_valid}, 32'd2);
`endif

    // Asynchronous reset in the middle of LD_MQ.
    cur_op = 3'b101; rdy_after = 2;
    req_valid = 1'b1; req_op = 3'b101; req_a = 8'h05; req_b = 8'h03;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_reset_ldmq", {23'd0, LDMQ, inBUS}, {23'd0, 1'b1, 8'h03});
    #2 reset = 1'b1;
    #1 check("async_reset_clear", {23'd0, LDMQ, busy, inBUS}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset", {30'd0, req_ready, resp_valid}, 32'd2);
    run_op(3'b100, 8'h11, 8'h11, 3, 8, 8'h01, 8'h21, 1'b0, 3);
    release_resp();

    check("strobe_exclusive", excl_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
